// File: rtl/bcell_mult_seq.sv
// Sequential shift-add multiplier driving one Bcell row per cycle; one
// multiplier bit per RUN cycle, result registered on the final add.
//   state | meaning
//   IDLE  | waiting for start, operands and product held
//   RUN   | one add/shift step per edge, row_h = current multiplier bit
//   DONE  | product valid, done pulse, back to IDLE next edge
module bcell_mult_seq #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done,
  output logic                 row_h
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-2:0] p_lo;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] p_hi;
  logic [WIDTH:0]   s;
  logic             last;

  // After each shift the top bit of P_hi is exactly the adder carry-out,
  // so that bit is stored once, as carry.
  assign p_hi = {carry, p_lo};
  assign last = (cnt == CW'(WIDTH - 1));

  always_comb begin
    s = {1'b0, p_hi} + (q[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_r     <= '0;
      q       <= '0;
      p_lo    <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      row_h   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_r   <= a;
            q     <= b;
            p_lo  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            row_h <= b[0];
            state <= RUN;
          end
        end
        RUN: begin
          {carry, p_lo, q} <= {s, q[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (last) begin
            product <= {s, q[WIDTH-1:1]};
            done    <= 1'b1;
            row_h   <= 1'b0;
            state   <= DONE;
          end else begin
            // next cycle's Q[0] is the bit about to shift down
            row_h <= q[1];
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          row_h <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcell_mult_seq.sv
// Bench for bcell_mult_seq: directed cases, reset abort, back-to-back
// starts, exhaustive 4-bit and random 8-bit operands against plain a*b.
module tb_bcell_mult_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        start4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic [7:0]  product4;
  logic        busy4, done4, row_h4;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] product8;
  logic        busy8, done8, row_h8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcell_mult_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .product(product4), .busy(busy4), .done(done4), .row_h(row_h4)
  );

  bcell_mult_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .product(product8), .busy(busy8), .done(done8), .row_h(row_h8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // done must never last two cycles; product may only move with done or reset
  logic        pd4 = 1'b0, pd8 = 1'b0;
  logic [7:0]  pp4 = '0;
  logic [15:0] pp8 = '0;
  always @(negedge clk) begin
    if (pd4) check("done4_twice", done4, 0);
    if (pd8) check("done8_twice", done8, 0);
    if (!rst && product4 !== pp4) check("prod4_hold", done4, 1);
    if (!rst && product8 !== pp8) check("prod8_hold", done8, 1);
    pd4 = done4;
    pd8 = done8;
    pp4 = product4;
    pp8 = product8;
  end

  task automatic run_op(input bit wide, input logic [7:0] a, input logic [7:0] b);
    int          w;
    int          n;
    logic [15:0] exp;
    w   = wide ? 8 : 4;
    exp = wide ? 16'(a) * 16'(b) : 16'(a[3:0]) * 16'(b[3:0]);
    n = 0;
    @(negedge clk);
    while ((wide ? busy8 : busy4) && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("idle_before_start", wide ? busy8 : busy4, 0);
    if (wide) begin start8 = 1'b1; a8 = a; b8 = b; end
    else begin start4 = 1'b1; a4 = a[3:0]; b4 = b[3:0]; end
    @(posedge clk);
    #1;
    // operands scrambled after acceptance must not disturb the result
    start4 = 1'b0; start8 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom);
    a8 = 8'($urandom); b8 = 8'($urandom);
    for (int i = 0; i < w; i++) begin
      @(negedge clk);
      check("run_busy", wide ? busy8 : busy4, 1);
      check("run_done", wide ? done8 : done4, 0);
      check("run_row_h", wide ? row_h8 : row_h4, b[i]);
    end
    @(negedge clk);
    check("done_pulse", wide ? done8 : done4, 1);
    check("done_busy", wide ? busy8 : busy4, 1);
    check("done_product", wide ? product8 : 16'(product4), exp);
    @(negedge clk);
    check("idle_done", wide ? done8 : done4, 0);
    check("idle_busy", wide ? busy8 : busy4, 0);
    check("idle_row_h", wide ? row_h8 : row_h4, 0);
    check("idle_product", wide ? product8 : 16'(product4), exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int last_i;
    int pulses;
    int seen;

    #1 rst = 1'b1;
    #1;
    check("rst_product4", product4, 0);
    check("rst_busy4", busy4, 0);
    check("rst_done4", done4, 0);
    check("rst_row_h4", row_h4, 0);
    check("rst_product8", product8, 0);
    check("rst_busy8", busy8, 0);
    @(negedge clk);
    #2 rst = 1'b0;

    run_op(0, 8'd15, 8'd15);
    run_op(0, 8'd0, 8'd9);
    run_op(0, 8'd9, 8'd0);
    run_op(0, 8'd13, 8'd11);

    // start held high: a new operation every WIDTH+2 edges
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd3; b4 = 4'd5;
    last_i = -1;
    pulses = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done4) begin
        pulses++;
        check("cont_product", product4, 15);
        if (last_i >= 0) check("cont_gap", i - last_i, 6);
        last_i = i;
      end
    end
    start4 = 1'b0;
    check("cont_pulses", pulses, 5);

    // reset during the second RUN cycle aborts the operation
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd7; b4 = 4'd7;
    @(posedge clk);
    #1 start4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", busy4, 0);
    check("abort_product", product4, 0);
    check("abort_done", done4, 0);
    check("abort_row_h", row_h4, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done4) seen = 1;
    end
    check("abort_no_done", seen, 0);
    check("abort_product_hold", product4, 0);
    run_op(0, 8'd2, 8'd3);

    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        run_op(0, 8'(x), 8'(y));

    run_op(1, 8'd255, 8'd255);
    run_op(1, 8'd0, 8'd255);
    repeat (150) run_op(1, 8'($urandom), 8'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
